dmem_arbiter: RTL and testbench

//  Shares the single-port Data_Memory between the RV32IM core load/store path (CPU) and the

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arb_pick.sv | 43 ++++
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Purpose : shared types and counter widths for the Data_Memory arbiter.
// Latency : n/a (types only).
// Backpressure: n/a.
package dmem_arb_pkg;

    typedef enum logic {
        ARB      = 1'b0,   // normal CPU-priority arbitration
        ACC_LOCK = 1'b1    // accelerator owns the memory port
    } arb_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_ACC = 1'b1
    } req_id_t;

    // MAX_WAIT is limited to 1..15, MAX_LOCK to 1..255
    localparam int STARVE_W = 4;
    localparam int LOCK_W   = 8;

endpackage

// File: rtl/dmem_arb_pick.sv
// Purpose : combinational grant decision for the Data_Memory arbiter.
// Latency : zero (pure combinational).
// Backpressure: the requester not picked simply holds its request.
//
// Ports: state/force_cpu/starve_cnt from the top's registers, cpu_req/acc_req
//        from the requesters; gnt_vld/gnt_id name the single winner (if any).
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  arb_state_t          state,
    input  logic                cpu_req,
    input  logic                acc_req,
    input  logic                force_cpu,
    input  logic [STARVE_W-1:0] starve_cnt,
    output req_id_t             gnt_id,
    output logic                gnt_vld
);

    always_comb begin
        gnt_id  = REQ_CPU;
        gnt_vld = 1'b0;
        if (state == ACC_LOCK) begin
            // locked: CPU is shut out regardless of priority
            gnt_id  = REQ_ACC;
            gnt_vld = acc_req;
        end else if (cpu_req && acc_req) begin
            gnt_vld = 1'b1;
            // the cycle right after a lock timeout belongs to the CPU, even if
            // the accelerator has hit its starvation limit meanwhile
            if (!force_cpu && (starve_cnt == STARVE_W'(MAX_WAIT))) begin
                gnt_id = REQ_ACC;
            end
        end else if (acc_req) begin
            gnt_vld = 1'b1;
            gnt_id  = REQ_ACC;
        end else if (cpu_req) begin
            gnt_vld = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose : shares single-port Data_Memory between the CPU load/store path and
//           the accelerator; CPU priority, ACC anti-starvation and ACC lock.
// Latency : grant and memory drive combinational; read data one cycle after grant.
// Backpressure: requests are held by the requester until *_gnt; no queuing inside.
//
// Ports: clk/reset (sync, active high); cpu_* and acc_* requester interfaces
//        (req/we/addr/wdata in, gnt/rvalid/rdata out, acc_lock in);
//        dm_write_en/dm_address/dm_in to Data_Memory, dm_out back from it.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic              acc_lock,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic              acc_gnt,
    output logic              acc_rvalid,
    output logic [DATA_W-1:0] acc_rdata,
    output logic              dm_write_en,
    output logic [ADDR_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_in,
    input  logic [DATA_W-1:0] dm_out
);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [STARVE_W-1:0] starve_cnt;
    logic [LOCK_W-1:0]   lock_cnt;
    logic                force_cpu;
    logic                lock_timeout;
    req_id_t             pick_id;
    logic                pick_vld;
    logic                cpu_rvalid_q;
    logic                acc_rvalid_q;

    dmem_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
        .state      (state),
        .cpu_req    (cpu_req),
        .acc_req    (acc_req),
        .force_cpu  (force_cpu),
        .starve_cnt (starve_cnt),
        .gnt_id     (pick_id),
        .gnt_vld    (pick_vld)
    );

    // The cycle that observes lock_cnt==MAX_LOCK is the last locked cycle:
    // ACC may still be served in it, and the following cycle is back in ARB.
    assign lock_timeout = (state == ACC_LOCK) && (lock_cnt == LOCK_W'(MAX_LOCK));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ARB: begin
                if (acc_gnt && acc_lock) begin
                    state_nxt = ACC_LOCK;
                end
            end
            ACC_LOCK: begin
                // acc_lock low covers both "released at a grant" and "idle, unlocked"
                if (!acc_lock || lock_timeout) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cpu_gnt     = !reset && pick_vld && (pick_id == REQ_CPU);
        acc_gnt     = !reset && pick_vld && (pick_id == REQ_ACC);
        dm_write_en = 1'b0;
        dm_address  = cpu_addr;
        dm_in       = cpu_wdata;
        if (acc_gnt) begin
            dm_write_en = acc_we;
            dm_address  = acc_addr;
            dm_in       = acc_wdata;
        end else if (cpu_gnt) begin
            dm_write_en = cpu_we;
        end
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            lock_cnt   <= '0;
            force_cpu  <= 1'b0;
        end else begin
            if (acc_gnt) begin
                starve_cnt <= '0;
            end else if (acc_req && (starve_cnt != STARVE_W'(MAX_WAIT))) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end

            // held at zero in ARB so every lock episode starts from 0
            if (state == ARB) begin
                lock_cnt <= '0;
            end else if (cpu_req && (lock_cnt != LOCK_W'(MAX_LOCK))) begin
                lock_cnt <= lock_cnt + LOCK_W'(1);
            end

            force_cpu <= lock_timeout;
        end
    end

    // ---------------- read responses ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rvalid_q <= 1'b0;
            acc_rvalid_q <= 1'b0;
            cpu_rdata    <= '0;
            acc_rdata    <= '0;
        end else begin
            cpu_rvalid_q <= cpu_gnt && !cpu_we;
            acc_rvalid_q <= acc_gnt && !acc_we;
            if (cpu_gnt && !cpu_we) begin
                cpu_rdata <= dm_out;
            end
            if (acc_gnt && !acc_we) begin
                acc_rdata <= dm_out;
            end
        end
    end

    // a read granted just before reset must not surface during the reset cycle
    assign cpu_rvalid = cpu_rvalid_q && !reset;
    assign acc_rvalid = acc_rvalid_q && !reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/100ps
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        acc_req = 1'b0, acc_we = 1'b0, acc_lock = 1'b0;
    logic [31:0] acc_addr = '0, acc_wdata = '0;
    logic        acc_gnt, acc_rvalid;
    logic [31:0] acc_rdata;
    logic        dm_write_en;
    logic [31:0] dm_address, dm_in, dm_out;

    int errors = 0;
    int checks = 0;

    always #1 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .MAX_LOCK(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .acc_req(acc_req), .acc_we(acc_we), .acc_lock(acc_lock), .acc_addr(acc_addr),
        .acc_wdata(acc_wdata), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
        .dm_write_en(dm_write_en), .dm_address(dm_address), .dm_in(dm_in), .dm_out(dm_out)
    );

    // Data_Memory: combinational read, write at the clock edge
    logic [31:0] mem [0:63];
    assign dm_out = mem[dm_address[5:0]];
    always @(posedge clk) begin
        if (dm_write_en) mem[dm_address[5:0]] <= dm_in;
    end

    // reference memory and read-data scoreboards
    logic [31:0] ref_mem [0:63];
    logic [31:0] cpu_q[$];
    logic [31:0] acc_q[$];
    logic        exp_crv = 1'b0;
    logic        exp_arv = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample 0.5 before the next posedge.
    task automatic step(input logic rst,
                        input logic c_req, input logic c_we, input logic [31:0] c_addr, input logic [31:0] c_wd,
                        input logic a_req, input logic a_we, input logic a_lk, input logic [31:0] a_addr, input logic [31:0] a_wd,
                        input logic e_cg, input logic e_ag, input string tag);
        logic [31:0] e;
        @(negedge clk);
        reset = rst;
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        acc_req = a_req; acc_we = a_we; acc_lock = a_lk; acc_addr = a_addr; acc_wdata = a_wd;
        #0.5;
        // responses to last cycle's grants
        chk({tag, "/cpu_rvalid"}, {31'b0, cpu_rvalid}, {31'b0, exp_crv && !rst});
        chk({tag, "/acc_rvalid"}, {31'b0, acc_rvalid}, {31'b0, exp_arv && !rst});
        if (exp_crv && !rst && cpu_q.size() > 0) begin
            e = cpu_q.pop_front();
            chk({tag, "/cpu_rdata"}, cpu_rdata, e);
        end
        if (exp_arv && !rst && acc_q.size() > 0) begin
            e = acc_q.pop_front();
            chk({tag, "/acc_rdata"}, acc_rdata, e);
        end
        if (rst) begin
            cpu_q.delete();
            acc_q.delete();
        end
        // this cycle's grant and memory drive
        chk({tag, "/cpu_gnt"}, {31'b0, cpu_gnt}, {31'b0, e_cg});
        chk({tag, "/acc_gnt"}, {31'b0, acc_gnt}, {31'b0, e_ag});
        if (e_cg) begin
            chk({tag, "/dm_address"}, dm_address, c_addr);
            chk({tag, "/dm_write_en"}, {31'b0, dm_write_en}, {31'b0, c_we});
            if (c_we) ref_mem[c_addr[5:0]] = c_wd;
            else cpu_q.push_back(ref_mem[c_addr[5:0]]);
        end else if (e_ag) begin
            chk({tag, "/dm_address"}, dm_address, a_addr);
            chk({tag, "/dm_write_en"}, {31'b0, dm_write_en}, {31'b0, a_we});
            if (a_we) ref_mem[a_addr[5:0]] = a_wd;
            else acc_q.push_back(ref_mem[a_addr[5:0]]);
        end else begin
            chk({tag, "/dm_write_en_idle"}, {31'b0, dm_write_en}, 32'h0);
        end
        exp_crv = e_cg && !c_we;
        exp_arv = e_ag && !a_we;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end

        // 1. reset held 3 cycles with a pending CPU write
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b1, 32'd3, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "reset");
        idle("post_reset");
        chk("post_reset/cpu_rdata", cpu_rdata, 32'h0);
        chk("post_reset/acc_rdata", acc_rdata, 32'h0);

        // 2. CPU write then read of addr 5; addr 3 must be untouched by the reset-time request
        step(1'b0, 1'b1, 1'b1, 32'd5, 32'hABCDEFF0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "cpu_wr5");
        step(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "cpu_rd5");
        step(1'b0, 1'b1, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "cpu_rd3");
        idle("idle_a");
        idle("idle_b");
        chk("rdata_hold", cpu_rdata, 32'h0);

        // 3. both read every cycle: CPU x4, ACC on the 5th, CPU again after the counter clears
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0,
                 (i != 4), (i == 4), $sformatf("starve%0d", i));
        idle("idle_c");

        // 4. locked ACC write + 3 locked reads with CPU waiting, then CPU
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd8, 32'h11111111, 1'b0, 1'b1, "lock_wr8");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b1, 1'b0, (i != 2), 32'd8, 32'd0,
                 1'b0, 1'b1, $sformatf("lock_rd%0d", i));
        step(1'b0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "unlock_cpu");
        idle("idle_d");

        // 5. lock timeout: lock_cnt counts 16 waiting cycles, the cycle that sees 16
        //    is the last locked one (17 locked grants), then CPU wins
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0, 1'b0, 1'b1, "to_enter");
        for (int i = 0; i < 17; i++)
            step(1'b0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b1, 1'b0, 1'b1, 32'd8, 32'd0,
                 1'b0, 1'b1, $sformatf("to_lock%0d", i));
        step(1'b0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b1, 1'b0, 1'b1, 32'd8, 32'd0, 1'b1, 1'b0, "to_cpu");
        idle("idle_e");

        // 6. locked ACC read, reset next cycle: no rvalid, back in ARB afterwards
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd8, 32'd0, 1'b0, 1'b1, "pre_rst_rd");
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "rst2");
        idle("post_rst2");
        chk("post_rst2/acc_rdata", acc_rdata, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, "arb_after_rst");
        idle("idle_f");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
